// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer holds tx_valid/tx_data until it sees tx_ready.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer advanced by a one-cycle baud tick: start, LSB-first data, [parity], stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 baud_tick,
    uart_tx_serializer_if.slave  bus,
    output logic                 tx_busy,
    output logic                 tx
);
    localparam int              CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q;
    logic                 busy_q;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
    logic par_calc;

    // Parity is frozen at accept so later changes on tx_data cannot leak in.
    assign par_calc = (^bus.tx_data) ^ PARITY_ODD;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // A tick on the accept edge is consumed just to enter ARMED.
                if (bus.tx_valid) begin
                    shift_d = bus.tx_data;
                    state_d = S_ARMED;
`ifdef UART_TX_PARITY_EN
                    par_d   = par_calc;
`endif
                end
            end
            S_ARMED: begin
                if (baud_tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state_d    = S_PARITY;
                        tx_d       = par_q;
`else
                        state_d    = S_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q != LAST_STOP) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx_ready = ready_q;
    assign tx_busy      = busy_q;
    assign tx           = tx_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level model checked every cycle plus literal frame patterns.
// Two instances: 8-1 even and 8-2 odd; parity cases follow UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
    localparam int PERIOD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam int          L_55 = 11;
    localparam logic [63:0] E_55 = {1'b0, 8'b10101010, 1'b0, 1'b1};
    localparam int          L_07A = 11;
    localparam logic [63:0] E_07A = {1'b0, 8'b11100000, 1'b1, 1'b1};
    localparam int          L_07B = 12;
    localparam logic [63:0] E_07B = {1'b0, 8'b11100000, 1'b0, 2'b11};
    localparam int          L_H = 25;
    localparam logic [63:0] E_H = {1'b0, 8'b11000101, 1'b1, 2'b11, 1'b1,
                                   1'b0, 8'b00111100, 1'b1, 2'b11};
    localparam int          L_00 = 11;
    localparam logic [63:0] E_00 = {1'b0, 8'b00000000, 1'b0, 1'b1};
    localparam int          L_FF = 11;
    localparam logic [63:0] E_FF = {1'b0, 8'b11111111, 1'b0, 1'b1};
`else
    localparam int P = 0;
    localparam int          L_55 = 10;
    localparam logic [63:0] E_55 = {1'b0, 8'b10101010, 1'b1};
    localparam int          L_07A = 10;
    localparam logic [63:0] E_07A = {1'b0, 8'b11100000, 1'b1};
    localparam int          L_07B = 11;
    localparam logic [63:0] E_07B = {1'b0, 8'b11100000, 2'b11};
    localparam int          L_H = 23;
    localparam logic [63:0] E_H = {1'b0, 8'b11000101, 2'b11, 1'b1,
                                   1'b0, 8'b00111100, 2'b11};
    localparam int          L_00 = 10;
    localparam logic [63:0] E_00 = {1'b0, 8'b00000000, 1'b1};
    localparam int          L_FF = 10;
    localparam logic [63:0] E_FF = {1'b0, 8'b11111111, 1'b1};
`endif

    logic clk_in    = 1'b0;
    logic rst       = 1'b1;
    logic baud_tick = 1'b0;
    logic tx0, tx1, busy0, busy1;
    logic       v [2];
    logic [7:0] d [2];
    int n_cmp = 0;
    int n_err = 0;
    bit tick_stuck = 1'b0;
    bit tick_prev  = 1'b0;
    logic [15:0] mframe [2];
    int          mlen   [2];
    logic [63:0] rec    [2];
    int          rcnt   [2];

    uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
    assign if0.tx_valid = v[0];
    assign if0.tx_data  = d[0];
    assign if1.tx_valid = v[1];
    assign if1.tx_data  = d[1];

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_dut0 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick),
        .bus(if0.slave), .tx_busy(busy0), .tx(tx0));
    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick),
        .bus(if1.slave), .tx_busy(busy1), .tx(tx1));

    initial forever #5 clk_in = ~clk_in;

    function automatic logic dut_tx(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction
    function automatic logic dut_rdy(input int k);
        return (k == 0) ? if0.tx_ready : if1.tx_ready;
    endfunction
    function automatic logic dut_busy(input int k);
        return (k == 0) ? busy0 : busy1;
    endfunction

    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_in);
            if (tick_stuck) baud_tick = 1'b1;
            else begin
                cnt = (cnt + 1) % PERIOD;
                baud_tick = (cnt == 0);
            end
        end
    end

    // Model: a frame is a list of line levels (ARMED high, start, data, parity, stops);
    // each tick drops the head, an empty list means idle.
    initial begin : model
        for (int k = 0; k < 2; k++) begin
            mlen[k] = 0;
            mframe[k] = '0;
            rcnt[k] = 0;
            rec[k] = '0;
        end
        forever begin
            @(posedge clk_in or posedge rst);
            tick_prev = !rst && baud_tick;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    mlen[k] = 0;
                    mframe[k] = '0;
                end else if (mlen[k] == 0) begin
                    if (v[k]) begin
                        logic [15:0] f;
                        logic [7:0]  b;
                        int          pos;
                        b = d[k];
                        f = '0;
                        f[0] = 1'b1;
                        f[1] = 1'b0;
                        pos = 2;
                        for (int i = 0; i < 8; i++) begin f[pos] = b[i]; pos++; end
                        if (P == 1) begin f[pos] = (^b) ^ (k == 1); pos++; end
                        for (int s = 0; s < k + 1; s++) begin f[pos] = 1'b1; pos++; end
                        mframe[k] = f;
                        mlen[k] = pos;
                    end
                end else if (baud_tick) begin
                    mframe[k] = mframe[k] >> 1;
                    mlen[k] = mlen[k] - 1;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_in);
            for (int k = 0; k < 2; k++) begin
                logic [2:0] got, exp;
                logic etx;
                etx = (mlen[k] == 0) ? 1'b1 : mframe[k][0];
                exp = {etx, mlen[k] == 0, mlen[k] != 0};
                got = {dut_tx(k), dut_rdy(k), dut_busy(k)};
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL model_dut%0d t=%0t: {tx,ready,busy} got %b expected %b", k, $time, got, exp);
                end
                if (tick_prev && rcnt[k] < 64) begin
                    rec[k][rcnt[k]] = dut_tx(k);
                    rcnt[k]++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        int cyc;
        cyc = 0;
        ok = 1'b1;
        while (dut_rdy(k) !== 1'b1) begin
            step();
            cyc++;
            if (cyc > 500) begin
                ok = 1'b0;
                n_cmp++;
                n_err++;
                $display("FAIL timeout_dut%0d: ready low for %0d cycles, expected high", k, cyc);
                break;
            end
        end
    endtask

    task automatic check_levels(input string name, input int k, input int len, input logic [63:0] exp);
        logic [63:0] got;
        got = '0;
        for (int i = 0; i < len; i++) got[len-1-i] = rec[k][i];
        n_cmp++;
        if (rcnt[k] < len || got !== exp) begin
            n_err++;
            $display("FAIL %s: tick levels got %b (%0d ticks) expected %b", name, got, rcnt[k], exp);
        end
    endtask

    task automatic send_frame(input string name, input int k, input logic [7:0] b,
                              input int len, input logic [63:0] exp);
        bit ok;
        d[k] = b;
        v[k] = 1'b1;
        step();
        v[k] = 1'b0;
        rcnt[k] = 0;
        wait_ready(k, ok);
        check_levels(name, k, len, exp);
        if (ok) check({name, "_ticks_to_ready"}, rcnt[k], len + 1);
    endtask

    initial begin : stim
        bit ok;
        int n;
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = 8'h00; d[1] = 8'h00;
        repeat (3) step();
        check("rst_tx0", tx0, 1);
        check("rst_ready0", if0.tx_ready, 1);
        check("rst_busy0", busy0, 0);
        check("rst_tx1", tx1, 1);
        check("rst_ready1", if1.tx_ready, 1);
        rst = 1'b0;
        repeat (2) step();

        send_frame("frame_55", 0, 8'h55, L_55, E_55);
        send_frame("frame_07_a", 0, 8'h07, L_07A, E_07A);
        send_frame("frame_07_b", 1, 8'h07, L_07B, E_07B);

        // tx_valid held across two frames on the two-stop-bit instance
        d[1] = 8'hA3;
        v[1] = 1'b1;
        step();
        d[1] = 8'h3C;
        rcnt[1] = 0;
        wait_ready(1, ok);
        step();
        v[1] = 1'b0;
        check("held_valid_busy_after_2nd_accept", busy1, 1);
        wait_ready(1, ok);
        check_levels("held_valid_frames", 1, L_H, E_H);
        check("held_valid_ticks", rcnt[1], L_H + 1);

        // accept on the same edge as a tick
        n = 0;
        while (baud_tick !== 1'b1 && n < 20) begin step(); n++; end
        d[0] = 8'h81;
        v[0] = 1'b1;
        step();
        v[0] = 1'b0;
        n = 1;
        while (tx0 !== 1'b0 && n < 50) begin step(); n++; end
        check("tick_coincide_start_delay", n, PERIOD + 1);
        wait_ready(0, ok);
        step();

        // reset during data bit 3
        d[0] = 8'hF0;
        v[0] = 1'b1;
        step();
        v[0] = 1'b0;
        rcnt[0] = 0;
        n = 0;
        while (rcnt[0] < 5 && n < 100) begin step(); n++; end
        check("pre_rst_bit3_level", tx0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx0, 1);
        check("async_rst_ready", if0.tx_ready, 1);
        check("async_rst_busy", busy0, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        send_frame("after_rst_00", 0, 8'h00, L_00, E_00);

        // baud_tick stuck high: one bit per clock
        tick_stuck = 1'b1;
        repeat (2) step();
        send_frame("stuck_tick_ff", 0, 8'hFF, L_FF, E_FF);
        tick_stuck = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter that consumes the one-cycle baud tick from the baud clock divider. It serializes parallel bytes onto the `tx` line as asynchronous frames: a start bit, LSB-first data, an optional parity bit and the stop bit(s). It sits between the game logic's byte producer and the board's UART TX pin, and runs entirely in the `clk_in` domain with no derived clocks.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored unless parity is compiled in.
- `clk_in`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `baud_tick`  in  1  one-`clk_in`-cycle strobe, one per bit period, from the baud divider.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on the accept cycle.
- `tx_valid`  in  1  producer has data.
- `tx_ready`  out  1  block can accept; registered, high only in IDLE.
- `tx_busy`  out  1  frame in progress; registered, equals `!tx_ready`.
- `tx`  out  1  serial line; registered, idles high.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, state=IDLE, shift register=0, bit counter=0, stop counter=0.
- Accept: on a rising edge with `tx_valid && tx_ready`, the block:
  - latches `tx_data` into the shift register;
  - computes parity, when compiled in;
  - moves to ARMED.
- From ARMED on, every state change happens only on a `clk_in` edge where `baud_tick`=1. Cycles without a tick hold all state.
- State transitions, each on a tick:
  - ARMED → START: `tx`<=0.
  - START → DATA: `tx`<=bit0; bit counter=0.
  - DATA, counter < DATA_BITS-1: counter+1, `tx`<=next bit (LSB first).
  - DATA, last bit: go to PARITY with `tx`<=parity bit when compiled in; otherwise go to STOP with `tx`<=1.
  - PARITY → STOP: `tx`<=1; stop counter=0.
  - STOP, stop counter < STOP_BITS-1: stop counter+1.
  - STOP, last stop bit: go to IDLE with `tx`=1. `tx_ready` rises on that same edge.
- Bit counter width is `$clog2(DATA_BITS)`. It never wraps past DATA_BITS-1.
- Frame length is 1 + DATA_BITS + P + STOP_BITS ticks after ARMED, where P=1 when parity is compiled in and 0 otherwise.
- `tx_data` and `tx_valid` are ignored outside IDLE. No queueing.
- Accept coinciding with a tick while IDLE: accept happens, that tick is consumed only to enter ARMED. The start bit begins on the next tick.
- `tx_valid` high continuously: one frame per handshake. The next accept happens on the first edge after returning to IDLE.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronously) and the frame is discarded. No partial frame is resumed.
- `baud_tick` stuck high: the block advances one bit per `clk_in` cycle. This is legal; used for fast simulation.

## Timing
- Acceptance: `tx_ready` high in the cycle `tx_valid` is sampled.
- `tx` is a flop. Each bit starts the cycle after the tick edge that selects it.
- Start-bit latency after acceptance: from 1 to (tick period + 1) cycles, depending on tick phase.
- Each bit lasts exactly one tick period (10417 `clk_in` cycles at the default divider).
- `tx_ready` returns high at the start of the final stop bit's end. Minimum gap between frames: 1 tick period spent in ARMED.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - Parity bit = XOR of the data bits, inverted when `PARITY_ODD`=1.
  - Frame is 8E1 (or 8O1) at the defaults.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are absent.
  - DATA goes straight to STOP; frame is 8N1 at the defaults.
  - `PARITY_ODD` has no effect.

## Test plan
- Reset, then `baud_tick` every 4 cycles, parity off, send 0x55 → `tx` per tick: 0, 1,0,1,0,1,0,1,0, 1. Each level held 4 cycles; `tx_ready` back high after 10 ticks.
- `UART_TX_PARITY_EN`, even parity, send 0x07 → data 1,1,1,0,0,0,0,0, then parity 1, then stop 1. With `PARITY_ODD`=1 → parity 0.
- `tx_valid` held high with bytes 0xA3 then 0x3C, `STOP_BITS`=2 → two complete frames. Each has two stop ticks high; exactly one ARMED tick of idle high between frames.
- Assert `tx_valid` in the same cycle as `baud_tick` → `tx` stays 1 for one full tick period, then the start bit.
- Assert `rst` during data bit 3 → `tx`=1 and `tx_ready`=1 immediately. After release, a new 0x00 frame starts cleanly.
- `baud_tick` tied high, send 0xFF → full frame in 10 `clk_in` cycles: 0, eight 1s, stop 1.
